// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 scan-code receiver:
//   - ps2_state_e : receiver FSM states (IDLE, SHIFT, CHECK)
//   - BYTE_*      : prefix bytes and keyboard status bytes
//   - E1_SKIP_LEN : bytes swallowed after an E1 (Pause/Break) prefix
//   - is_status_byte() : true for bytes that are dropped without an event
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } ps2_state_e;

  // Prefix bytes
  localparam logic [7:0] BYTE_E0 = 8'hE0;  // extended key
  localparam logic [7:0] BYTE_F0 = 8'hF0;  // key release
  localparam logic [7:0] BYTE_E1 = 8'hE1;  // Pause/Break sequence

  // Keyboard status / protocol bytes that never produce a key event
  localparam logic [7:0] BYTE_AA = 8'hAA;  // self-test passed
  localparam logic [7:0] BYTE_FA = 8'hFA;  // ack
  localparam logic [7:0] BYTE_EE = 8'hEE;  // echo
  localparam logic [7:0] BYTE_FE = 8'hFE;  // resend
  localparam logic [7:0] BYTE_00 = 8'h00;  // buffer overrun
  localparam logic [7:0] BYTE_FF = 8'hFF;  // error / overrun

  // E1 is followed by 7 more bytes that describe Pause; none of them is a key
  localparam logic [2:0] E1_SKIP_LEN = 3'd7;

  function automatic logic is_status_byte(input logic [7:0] b);
    return (b == BYTE_AA) || (b == BYTE_FA) || (b == BYTE_EE) ||
           (b == BYTE_FE) || (b == BYTE_00) || (b == BYTE_FF);
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// ps2_filter
// Brings the raw PS/2 lines into the clk_24 domain and turns the keyboard
// clock into a clean single-cycle sample strobe.
// Ports:
//   clk_24, reset_n : system clock, async active-low reset
//   ps2_clk         : raw keyboard clock (asynchronous)
//   ps2_data        : raw keyboard data (asynchronous)
//   fall_pulse      : one-cycle pulse on each falling edge of the filtered clock
//   data_s          : synchronized ps2_data, sample it when fall_pulse is high
module ps2_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_24,
  input  logic reset_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall_pulse,
  output logic data_s
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    r_clk_sync;
  logic [1:0]    r_dat_sync;
  logic          r_clk_filt;
  logic [CW-1:0] r_cnt;
  logic          r_fall;
  logic          w_clk_s;

  assign w_clk_s    = r_clk_sync[1];
  assign data_s     = r_dat_sync[1];
  assign fall_pulse = r_fall;

  // Idle PS/2 lines are high, so the synchronizers and the filter reset to 1
  // to avoid a phantom falling edge right after reset.
  always_ff @(posedge clk_24 or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_clk_filt <= 1'b1;
      r_cnt      <= '0;
      r_fall     <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[0], ps2_clk};
      r_dat_sync <= {r_dat_sync[0], ps2_data};
      r_fall     <= 1'b0;
      // r_cnt counts consecutive samples that disagree with the filtered
      // level; any agreeing sample restarts the run, so glitches die here.
      if (w_clk_s == r_clk_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_cnt      <= '0;
        r_clk_filt <= w_clk_s;
        r_fall     <= ~w_clk_s;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx
// Receives 11-bit PS/2 keyboard frames and decodes scan-code set 2 key events
// (E0 extended prefix, F0 release prefix, E1 Pause sequence swallowed).
// Ports:
//   clk_24, reset_n : system clock, async active-low reset
//   ps2_clk/ps2_data: raw keyboard lines
//   key_strobe      : one-cycle pulse per decoded key event
//   key_pressed     : 1 = make, 0 = break (held until next strobe)
//   key_extended    : event had an E0 prefix (held until next strobe)
//   key_code        : final scan code byte (held until next strobe)
//   parity_err      : one-cycle pulse, frame failed odd parity
//   frame_err       : one-cycle pulse, bad start/stop bit or timeout
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 48000
) (
  input  logic       clk_24,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_strobe,
  output logic       key_pressed,
  output logic       key_extended,
  output logic [7:0] key_code,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          w_fall;
  logic          w_data;
  logic [7:0]    w_byte;
  logic          w_par_ok;
  logic          w_stop;

  ps2_state_e    r_state;
  logic [3:0]    r_bitcnt;
  logic [9:0]    r_frame;   // {stop, parity, data[7:0]} once complete
  logic [TW-1:0] r_to;
  logic          r_ext;
  logic          r_rel;
  logic [2:0]    r_skip;

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk_24     (clk_24),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .fall_pulse (w_fall),
    .data_s     (w_data)
  );

  assign w_byte   = r_frame[7:0];
  assign w_par_ok = ^r_frame[8:0];  // odd parity over data + parity bit
  assign w_stop   = r_frame[9];

  always_ff @(posedge clk_24 or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_bitcnt     <= '0;
      r_frame      <= '0;
      r_to         <= '0;
      r_ext        <= 1'b0;
      r_rel        <= 1'b0;
      r_skip       <= '0;
      key_strobe   <= 1'b0;
      key_pressed  <= 1'b0;
      key_extended <= 1'b0;
      key_code     <= '0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_to     <= '0;
          r_bitcnt <= '0;
          if (w_fall) begin
            if (!w_data) r_state   <= SHIFT;
            else         frame_err <= 1'b1;  // start bit must be 0
          end
        end

        SHIFT: begin
          if (w_fall) begin
            // LSB arrives first, so shift in from the top
            r_frame  <= {w_data, r_frame[9:1]};
            r_to     <= '0;
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt == 4'd9) r_state <= CHECK;
          end else if (r_to == TW'(TIMEOUT_CYCLES - 1)) begin
            // Keyboard went silent mid-frame; prefix flags survive so a
            // retransmitted byte still pairs with its earlier prefix.
            r_state   <= IDLE;
            r_frame   <= '0;
            r_bitcnt  <= '0;
            r_to      <= '0;
            frame_err <= 1'b1;
          end else begin
            r_to <= r_to + 1'b1;
          end
        end

        CHECK: begin
          r_state  <= IDLE;
          r_bitcnt <= '0;
          if (!w_par_ok || !w_stop) begin
            // parity_err wins when both faults are present
            if (!w_par_ok) parity_err <= 1'b1;
            else           frame_err  <= 1'b1;
            r_ext  <= 1'b0;
            r_rel  <= 1'b0;
            r_skip <= '0;
          end else if (r_skip != 3'd0) begin
            r_skip <= r_skip - 1'b1;
          end else if (w_byte == BYTE_E0) begin
            r_ext <= 1'b1;
          end else if (w_byte == BYTE_F0) begin
            r_rel <= 1'b1;
          end else if (w_byte == BYTE_E1) begin
            r_skip <= E1_SKIP_LEN;
          end else if (is_status_byte(w_byte)) begin
            r_ext <= 1'b0;
            r_rel <= 1'b0;
          end else begin
            key_strobe   <= 1'b1;
            key_code     <= w_byte;
            key_pressed  <= ~r_rel;
            key_extended <= r_ext;
            r_ext        <= 1'b0;
            r_rel        <= 1'b0;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
module tb_ps2_scancode_rx;

  localparam int FILT = 8;
  localparam int TMO  = 2000;
  localparam int HP   = 20;   // PS/2 half period in clk_24 cycles

  localparam int K_KEY  = 0;
  localparam int K_PERR = 1;
  localparam int K_FERR = 2;

  typedef struct {
    int         kind;
    logic [7:0] code;
    logic       pressed;
    logic       ext;
  } exp_t;

  logic       clk_24 = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_strobe, key_pressed, key_extended, parity_err, frame_err;
  logic [7:0] key_code;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   last_fall = 0;
  logic prev_strobe = 1'b0, prev_perr = 1'b0, prev_ferr = 1'b0;

  ps2_scancode_rx #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_24       (clk_24),
    .reset_n      (reset_n),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .key_strobe   (key_strobe),
    .key_pressed  (key_pressed),
    .key_extended (key_extended),
    .key_code     (key_code),
    .parity_err   (parity_err),
    .frame_err    (frame_err)
  );

  always #5 clk_24 = ~clk_24;
  always @(posedge clk_24) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input int kind, input logic [7:0] code, input logic pressed, input logic ext);
    exp_t e;
    e.kind = kind; e.code = code; e.pressed = pressed; e.ext = ext;
    q.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk_24);
    ps2_data = b;
    repeat (HP) @(negedge clk_24);
    ps2_clk = 1'b0;
    last_fall = cyc;
    repeat (HP) @(negedge clk_24);
    ps2_clk = 1'b1;
  endtask

  // nbits < 11 sends a truncated frame
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
    logic [10:0] fr;
    logic        par;
    par = ~(^b) ^ bad_par;
    fr  = {~bad_stop, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(fr[i]);
    repeat (2 * HP) @(negedge clk_24);
    ps2_data = 1'b1;
  endtask

  task automatic key(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_strobe"},   int'(key_strobe),   0);
    check({tag, "_pressed"},  int'(key_pressed),  0);
    check({tag, "_extended"}, int'(key_extended), 0);
    check({tag, "_code"},     int'(key_code),     0);
    check({tag, "_perr"},     int'(parity_err),   0);
    check({tag, "_ferr"},     int'(frame_err),    0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents any output pulse
  always @(negedge clk_24) begin
    if (reset_n) begin
      if (key_strobe) check("strobe_width", int'(prev_strobe), 0);
      if (parity_err) check("perr_width",   int'(prev_perr),   0);
      if (frame_err)  check("ferr_width",   int'(prev_ferr),   0);
      if (key_strobe || parity_err || frame_err) begin
        int   kind;
        exp_t e;
        kind = key_strobe ? K_KEY : (parity_err ? K_PERR : K_FERR);
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: got kind %0d code %0h, expected nothing (cycle %0d)",
                   kind, key_code, cyc);
        end else begin
          e = q.pop_front();
          check("kind", kind, e.kind);
          check("single_pulse", int'(key_strobe) + int'(parity_err) + int'(frame_err), 1);
          if (e.kind == K_KEY) begin
            check("key_code",     int'(key_code),     int'(e.code));
            check("key_pressed",  int'(key_pressed),  int'(e.pressed));
            check("key_extended", int'(key_extended), int'(e.ext));
            check("latency",      cyc - last_fall,    FILT + 4);
          end
        end
      end
    end
    prev_strobe = key_strobe;
    prev_perr   = parity_err;
    prev_ferr   = frame_err;
  end

  initial begin
    repeat (3) @(negedge clk_24);
    reset_checks("rst");
    reset_n = 1'b1;
    repeat (10) @(negedge clk_24);

    // plain make code
    push(K_KEY, 8'h1C, 1'b1, 1'b0);
    key(8'h1C);

    // extended release
    push(K_KEY, 8'h75, 1'b0, 1'b1);
    key(8'hE0); key(8'hF0); key(8'h75);

    // bad parity, then recovery
    push(K_PERR, 8'h00, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b0, 11);
    push(K_KEY, 8'h29, 1'b1, 1'b0);
    key(8'h29);

    // truncated frame then silence beyond the timeout
    push(K_FERR, 8'h00, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, 5);
    repeat (TMO + 1000) @(negedge clk_24);
    push(K_KEY, 8'h1C, 1'b1, 1'b0);
    key(8'h1C);

    // timeout keeps the E0 prefix
    key(8'hE0);
    push(K_FERR, 8'h00, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0, 4);
    repeat (TMO + 500) @(negedge clk_24);
    push(K_KEY, 8'h75, 1'b1, 1'b1);
    key(8'h75);

    // Pause sequence is swallowed entirely
    key(8'hE1); key(8'h14); key(8'h77); key(8'hE1);
    key(8'hF0); key(8'h14); key(8'hF0); key(8'h77);
    push(K_KEY, 8'h29, 1'b1, 1'b0);
    key(8'h29);

    // 3-cycle glitch on the clock line is filtered out
    @(negedge clk_24); ps2_clk = 1'b0;
    repeat (3) @(negedge clk_24); ps2_clk = 1'b1;
    repeat (40) @(negedge clk_24);

    // lone clock edge with data high: bad start bit
    push(K_FERR, 8'h00, 1'b0, 1'b0);
    send_bit(1'b1);
    repeat (40) @(negedge clk_24);

    // bad stop bit only -> frame_err; both faults -> parity_err only
    push(K_FERR, 8'h00, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b1, 11);
    push(K_PERR, 8'h00, 1'b0, 1'b0);
    send_frame(8'h55, 1'b1, 1'b1, 11);

    // an error clears a pending release prefix
    key(8'hF0);
    push(K_PERR, 8'h00, 1'b0, 1'b0);
    send_frame(8'h12, 1'b1, 1'b0, 11);
    push(K_KEY, 8'h1C, 1'b1, 1'b0);
    key(8'h1C);

    // status byte clears a pending extended prefix
    key(8'hE0); key(8'hAA);
    push(K_KEY, 8'h74, 1'b1, 1'b0);
    key(8'h74);

    // reset mid-frame discards it
    send_frame(8'h1C, 1'b0, 1'b0, 4);
    reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk_24);
    reset_checks("midrst");
    reset_n = 1'b1;
    repeat (10) @(negedge clk_24);
    push(K_KEY, 8'h1C, 1'b1, 1'b0);
    key(8'h1C);

    repeat (100) @(negedge clk_24);
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
